// File: rtl/data_mem_lsu.sv
// Load/store unit in front of a 16x24-bit synchronous data memory.
// Handles one request at a time, byte-lane loads and read-modify-write byte stores.
module data_mem_lsu #(
    parameter int unsigned DW    = 24,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic          req_byte,
    input  logic [1:0]    req_lane,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          resp_err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StResp} state_e;

    localparam logic [AW:0] DepthLim = DEPTH[AW:0];

    state_e        state_q, state_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic [DW-1:0] resp_data_q, resp_data_d;
    logic          resp_err_q, resp_err_d;
    logic          store_q, store_d;
    logic          byte_q, byte_d;
    logic [1:0]    lane_q, lane_d;
    logic          sgn_q, sgn_d;
    logic [7:0]    wbyte_q, wbyte_d;

    logic          req_err;
    logic [7:0]    lane_byte;
    logic [DW-1:0] merged;

    assign req_ready = (state_q == StIdle) && !rst;
    assign req_err   = ({1'b0, req_addr} >= DepthLim) || (req_lane == 2'd3) ||
                       (!req_byte && (req_lane != 2'd0));

    // Lane extraction and merge both work on the word returned during WAIT.
    always_comb begin
        merged = mem_dout;
        case (lane_q)
            2'd0: begin
                lane_byte    = mem_dout[7:0];
                merged[7:0]  = wbyte_q;
            end
            2'd1: begin
                lane_byte    = mem_dout[15:8];
                merged[15:8] = wbyte_q;
            end
            default: begin
                lane_byte     = mem_dout[23:16];
                merged[23:16] = wbyte_q;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        store_d     = store_q;
        byte_d      = byte_q;
        lane_d      = lane_q;
        sgn_d       = sgn_q;
        wbyte_d     = wbyte_q;
        case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    store_d     = req_we;
                    byte_d      = req_byte;
                    lane_d      = req_lane;
                    sgn_d       = req_signed;
                    wbyte_d     = req_wdata[7:0];
                    resp_data_d = '0;
                    resp_err_d  = req_err;
                    if (req_err) begin
                        state_d = StResp;
                    end else begin
                        mem_addr_d = req_addr;
                        if (req_we && !req_byte) begin
                            mem_we_d  = 1'b1;
                            mem_din_d = req_wdata;
                            state_d   = StWrite;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                if (store_q) begin
                    mem_we_d  = 1'b1;
                    mem_din_d = merged;
                    state_d   = StWrite;
                end else begin
                    resp_data_d = byte_q ? {{(DW-8){sgn_q & lane_byte[7]}}, lane_byte} : mem_dout;
                    state_d     = StResp;
                end
            end
            StWrite: state_d = StResp;
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            store_q     <= 1'b0;
            byte_q      <= 1'b0;
            lane_q      <= 2'd0;
            sgn_q       <= 1'b0;
            wbyte_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            store_q     <= store_d;
            byte_q      <= byte_d;
            lane_q      <= lane_d;
            sgn_q       <= sgn_d;
            wbyte_q     <= wbyte_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign resp_valid = (state_q == StResp);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: a driver queues expected responses and writes,
// a monitor pops and compares them as the DUT presents them.
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_we, req_byte, req_signed;
    logic [1:0]  req_lane;
    logic [4:0]  req_addr;
    logic [23:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [23:0] resp_data;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [23:0] mem_din, mem_dout;

    typedef struct {logic [23:0] data; logic err; int due;} resp_t;
    typedef struct {logic [4:0] addr; logic [23:0] data; int due;} wr_t;

    resp_t       rq[$];
    wr_t         wq[$];
    logic [23:0] ref_mem[16];
    logic [23:0] mem[16];
    logic        load_mem = 1'b1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_lsu #(.DW(24), .AW(5), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
        .req_lane(req_lane), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Synchronous memory with one-cycle registered read.
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= ref_mem[i];
        end else if (mem_we && mem_addr < 5'd16) begin
            mem[mem_addr[3:0]] <= mem_din;
        end
        mem_dout <= (mem_addr < 5'd16) ? mem[mem_addr[3:0]] : 24'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    task automatic issue(input bit we, input bit byt, input logic [1:0] lane, input bit sgn,
                         input logic [4:0] addr, input logic [23:0] wd, input bit track);
        resp_t      r;
        wr_t        w;
        int         n;
        int         sh;
        logic       err;
        logic [7:0] b;
        logic [23:0] old;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1) begin
            n++;
            if (n > 200) begin
                chk("req_ready_timeout", 32'(req_ready), 32'd1);
                summary();
                $fatal(1, "request channel stuck");
            end
            @(negedge clk);
        end
        err    = (addr >= 5'd16) || (lane == 2'd3) || (!byt && lane != 2'd0);
        sh     = 8 * int'(lane);
        old    = ref_mem[addr[3:0]];
        r.err  = err;
        r.data = 24'h0;
        w.addr = addr;
        w.data = wd;
        w.due  = 0;
        if (err) begin
            r.due = cyc + 1;
        end else if (!we) begin
            r.due = cyc + 3;
            if (!byt) begin
                r.data = old;
            end else begin
                b      = 8'((old >> sh) & 24'hFF);
                r.data = (sgn && b[7]) ? {16'hFFFF, b} : {16'h0000, b};
            end
        end else begin
            r.due  = cyc + (byt ? 4 : 2);
            w.due  = cyc + (byt ? 3 : 1);
            w.data = byt ? ((old & ~(24'hFF << sh)) | (24'(wd[7:0]) << sh)) : wd;
        end
        if (track) begin
            rq.push_back(r);
            if (we && !err) begin
                wq.push_back(w);
                ref_mem[addr[3:0]] = w.data;
            end
        end
        req_we     = we;
        req_byte   = byt;
        req_lane   = lane;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(negedge clk);
        // Noise while busy: must be ignored outside IDLE.
        req_we     = 1'($urandom);
        req_byte   = 1'($urandom);
        req_lane   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = 5'($urandom);
        req_wdata  = 24'($urandom);
        req_valid  = 1'($urandom);
    endtask

    initial begin : monitor
        bit    fresh;
        wr_t   w;
        resp_t r;
        fresh      = 1'b1;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                chk("write_expected", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    chk("write_addr", 32'(mem_addr), 32'(w.addr));
                    chk("write_data", 32'(mem_din), 32'(w.data));
                    chk("write_cycle", cyc, w.due);
                end
            end
            if (resp_valid === 1'b1) begin
                chk("resp_expected", 32'(rq.size() != 0), 32'd1);
                if (rq.size() != 0) begin
                    r = rq[0];
                    chk("resp_data", 32'(resp_data), 32'(r.data));
                    chk("resp_err", 32'(resp_err), 32'(r.err));
                    if (fresh) chk("resp_latency", cyc, r.due);
                    fresh = 1'b0;
                end
                resp_ready = ($urandom_range(0, 3) != 0);
                if (resp_ready && rq.size() != 0) begin
                    void'(rq.pop_front());
                    fresh = 1'b1;
                end
            end else begin
                resp_ready = 1'($urandom);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        summary();
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int n;
        for (int i = 0; i < 16; i++) ref_mem[i] = 24'($urandom);
        ref_mem[3] = 24'h654321;
        ref_mem[8] = 24'h999999;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_byte   = 1'b0;
        req_lane   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 5'd0;
        req_wdata  = 24'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_din", 32'(mem_din), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        load_mem = 1'b0;
        rst      = 1'b0;

        issue(0, 0, 2'd0, 0, 5'd3, 24'h0, 1);       // word load 0x654321
        issue(0, 1, 2'd1, 1, 5'd8, 24'h0, 1);       // 0xFFFF99
        issue(0, 1, 2'd1, 0, 5'd8, 24'h0, 1);       // 0x000099
        issue(0, 1, 2'd2, 0, 5'd3, 24'h0, 1);       // 0x000065
        issue(1, 1, 2'd1, 0, 5'd3, 24'h0000AB, 1);  // RMW -> 0x65AB21
        issue(0, 0, 2'd0, 0, 5'd3, 24'h0, 1);
        issue(1, 0, 2'd0, 0, 5'd0, 24'h123456, 1);
        issue(0, 0, 2'd0, 0, 5'd0, 24'h0, 1);
        issue(0, 0, 2'd0, 0, 5'd16, 24'h0, 1);      // out-of-range address
        issue(0, 1, 2'd3, 0, 5'd2, 24'h0, 1);       // lane 3
        issue(1, 0, 2'd1, 0, 5'd4, 24'h777777, 1);  // word access with lane
        issue(0, 0, 2'd0, 0, 5'd4, 24'h0, 1);

        // Reset during WAIT of a byte store: no write, no response.
        issue(1, 1, 2'd0, 0, 5'd5, 24'h0000CD, 0);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_req_ready", 32'(req_ready), 32'd1);
        issue(0, 0, 2'd0, 0, 5'd5, 24'h0, 1);

        for (int k = 0; k < 120; k++) begin
            bit         byt;
            logic [1:0] lane;
            byt  = 1'($urandom);
            lane = byt ? 2'($urandom_range(0, 3))
                       : (($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
            issue(1'($urandom), byt, lane, 1'($urandom), 5'($urandom_range(0, 19)),
                  24'($urandom), 1);
        end
        req_valid = 1'b0;

        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain_resp", 32'(rq.size()), 32'd0);
        chk("drain_write", 32'(wq.size()), 32'd0);
        for (int i = 0; i < 16; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));
        summary();
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Load/store unit sitting directly upstream of the 16x24-bit synchronous data memory; it is the only master on that memory's clk/we/addr/data_in/data_out ports.
- Accepts one core request at a time over a valid/ready handshake and absorbs the memory's 1-cycle registered read latency.
- Implements byte-lane loads (zero- or sign-extended) and byte-lane stores by read-modify-write; returns data and an error flag over a valid/ready response channel.

Parameters:
- DW, 24, memory word width in bits (3 byte lanes).
- AW, 5, memory address width.
- DEPTH, 16, number of implemented words; any address >= DEPTH is an error.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  core request present.
- req_ready  output  1  LSU can accept; high only in IDLE and not in reset.
- req_we  input  1  1=store, 0=load.
- req_byte  input  1  1=byte access, 0=full word.
- req_lane  input  2  byte lane 0..2 (lane 0 = bits 7:0); must be 0 for word access.
- req_signed  input  1  sign-extend byte loads.
- req_addr  input  AW  word address.
- req_wdata  input  DW  store data; byte stores use bits 7:0.
- resp_valid  output  1  response present; held until accepted.
- resp_ready  input  1  core accepts response.
- resp_data  output  DW  load result; 0 for stores and errors.
- resp_err  output  1  illegal request.
- mem_we  output  1  to memory we (registered).
- mem_addr  output  AW  to memory addr (registered).
- mem_din  output  DW  to memory data_in (registered).
- mem_dout  input  DW  from memory data_out; valid the cycle after mem_addr is presented.

Behaviour:
- Interface is one clock (clk) and a synchronous, active-high reset (rst).
- Reset values: state=IDLE, mem_we=0, mem_addr=0, mem_din=0, resp_valid=0, resp_data=0, resp_err=0. req_ready=0 while rst=1.
- Request fields are latched on the accept edge (req_valid & req_ready). Request inputs are ignored outside IDLE.
- Error check at accept: req_addr>=DEPTH, or req_lane==3, or (!req_byte & req_lane!=0). An error goes IDLE->RESP with resp_err=1, resp_data=0, and mem_we never asserts.
- States: IDLE, READ, WAIT, WRITE, RESP.
- Word store: IDLE->WRITE->RESP.
  - In WRITE: mem_we=1, mem_addr=addr, mem_din=wdata.
  - resp_valid is high 2 cycles after accept.
- Load: IDLE->READ->WAIT->RESP.
  - In READ: mem_addr=addr, mem_we=0.
  - In WAIT: capture mem_dout.
  - Word load returns the word unchanged.
  - Byte load returns the selected lane in bits 7:0. Upper bits are 0, or copies of bit 7 when req_signed=1.
  - resp_valid is high 3 cycles after accept.
- Byte store: IDLE->READ->WAIT->WRITE->RESP.
  - In WAIT: merge wdata[7:0] into the captured word at the lane; other lanes are unchanged.
  - In WRITE: the merged word is written.
  - resp_valid is high 4 cycles after accept.
- mem_we is high for exactly one cycle per store and 0 in every other state. mem_addr and mem_din hold their last values when idle.
- RESP: resp_valid=1 with stable resp_data/resp_err until resp_ready=1. The response is accepted on that edge and the next state is IDLE, so the back-to-back minimum is 1 IDLE cycle between requests.
- resp_ready high in a cycle where resp_valid=0 has no effect.
- Reset mid-operation: takes effect at the next edge from any state. Any in-flight request is dropped with no response. A write already presented (mem_we=1 that cycle) completes at that same edge; no further write occurs.
- No address wrap: addresses 16..31 are never forwarded to the memory.

Test Plan:
- Reset, then word load addr 3 (memory=0x654321) -> req_ready=0 for 3 cycles, resp_valid on cycle 3 after accept, resp_data=0x654321, resp_err=0, mem_we never high.
- Byte load addr 8 (0x999999), lane 1, req_signed=1 -> resp_data=0xFFFF99; repeat with req_signed=0 -> 0x000099; lane 2 of addr 3 -> 0x000065.
- Byte store 0xAB to addr 3 lane 1 -> single mem_we pulse on cycle 3 after accept with mem_din=0x65AB21; a following word load of addr 3 returns 0x65AB21.
- Word store 0x123456 to addr 0 with resp_ready held low 3 cycles -> mem_we pulse cycle 1, resp_valid held high with stable resp_data=0, resp_err=0 until resp_ready; req_ready returns 1 cycle after acceptance.
- Error requests: addr 16 load, lane 3 byte load, word store with lane 1 -> resp_err=1, resp_data=0, resp_valid 1 cycle after accept, mem_we stays 0, memory unchanged.
- Assert rst in the WAIT state of a byte store -> no mem_we, no resp_valid. After release req_ready=1 and the memory word is unchanged.
